// File: rtl/fb_cell_writer.sv
// Packs 1-bit cells MSB-first into PIX_PER_WORD-bit framebuffer words and writes one frame per frame_start.
// Latency: wren_a rises one cycle after the edge that accepts the last cell of a word; 20 cells per 21 cycles sustained.
// Backpressure: cell_ready is low outside FILL and during the single WRITE cycle; optional flush port under FB_CELL_WRITER_FLUSH_EN.
module fb_cell_writer #(
    parameter int          PIX_PER_WORD = 20,
    parameter logic [15:0] LAST_ADDR    = 16'hFFFF
) (
    input  logic                    clk108,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    cell_valid,
    input  logic                    cell_data,
`ifdef FB_CELL_WRITER_FLUSH_EN
    input  logic                    flush,
`endif
    output logic                    cell_ready,
    output logic [15:0]             address_a,
    output logic [PIX_PER_WORD-1:0] data_a,
    output logic                    wren_a,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CW = $clog2(PIX_PER_WORD + 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                  state;
    logic [PIX_PER_WORD-1:0] pack;
    logic [CW-1:0]           bit_cnt;

    logic                    take;
    logic [PIX_PER_WORD-1:0] pack_nxt;
    logic [CW-1:0]           cnt_nxt;
    logic                    word_full;
    logic                    flush_now;
    logic [PIX_PER_WORD-1:0] word_out;

    // cell_ready is a registered copy of "state is FILL", so a handshake implies FILL
    assign take = cell_valid && cell_ready;

    // Next packed bits/count including this cycle's cell; word_out is left-justified when flushing early
    always_comb begin
        pack_nxt  = take ? {pack[PIX_PER_WORD-2:0], cell_data} : pack;
        cnt_nxt   = take ? bit_cnt + 1'b1 : bit_cnt;
        word_full = (cnt_nxt == CW'(PIX_PER_WORD));
`ifdef FB_CELL_WRITER_FLUSH_EN
        flush_now = flush && (state == FILL) && (bit_cnt != '0);
        word_out  = pack_nxt << (CW'(PIX_PER_WORD) - cnt_nxt);
`else
        flush_now = 1'b0;
        word_out  = pack_nxt;
`endif
    end

    // Frame FSM with all outputs registered alongside the state
    always_ff @(posedge clk108 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pack       <= '0;
            bit_cnt    <= '0;
            address_a  <= '0;
            data_a     <= '0;
            wren_a     <= 1'b0;
            cell_ready <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (frame_start) begin
                        state      <= FILL;
                        address_a  <= '0;
                        bit_cnt    <= '0;
                        pack       <= '0;
                        cell_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FILL: begin
                    pack    <= pack_nxt;
                    bit_cnt <= cnt_nxt;
                    if (word_full || flush_now) begin
                        state      <= WRITE;
                        data_a     <= word_out;
                        wren_a     <= 1'b1;
                        cell_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    wren_a  <= 1'b0;
                    bit_cnt <= '0;
                    pack    <= '0;
                    if (address_a == LAST_ADDR) begin
                        state      <= DONE;
                        address_a  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        state      <= FILL;
                        address_a  <= address_a + 16'd1;
                        cell_ready <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    wren_a     <= 1'b0;
                    cell_ready <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_cell_writer.sv
// Directed bench for fb_cell_writer using a short 9-word frame (LAST_ADDR = 8).
// Inputs change 1 time unit after the rising edge; outputs are checked there and logged on the falling edge.
// Writes are logged and compared against the sequence the stimulus expects.
module tb_fb_cell_writer;

    logic        clk108 = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        cell_valid = 1'b0;
    logic        cell_data = 1'b0;
`ifdef FB_CELL_WRITER_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        cell_ready;
    logic [15:0] address_a;
    logic [19:0] data_a;
    logic        wren_a;
    logic        busy;
    logic        frame_done;

    fb_cell_writer #(.PIX_PER_WORD(20), .LAST_ADDR(16'd8)) dut (
        .clk108      (clk108),
        .reset       (reset),
        .frame_start (frame_start),
        .cell_valid  (cell_valid),
        .cell_data   (cell_data),
`ifdef FB_CELL_WRITER_FLUSH_EN
        .flush       (flush),
`endif
        .cell_ready  (cell_ready),
        .address_a   (address_a),
        .data_a      (data_a),
        .wren_a      (wren_a),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk108 = ~clk108;

    int total = 0;
    int bad   = 0;

    logic [15:0] log_addr[$];
    logic [19:0] log_data[$];
    logic [15:0] exp_addr[$];
    logic [19:0] exp_data[$];
    int          done_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every write-port strobe and frame_done pulse
    always @(negedge clk108) begin
        if (!reset) begin
            if (wren_a) begin
                log_addr.push_back(address_a);
                log_data.push_back(data_a);
            end
            if (frame_done) done_pulses++;
        end
    end

    task automatic step();
        @(posedge clk108);
        #1;
    endtask

    task automatic send_cell(input logic b, input bit gap);
        bit acc;
        int n;
        if (gap) begin
            cell_valid = 1'b0;
            step();
        end
        cell_valid = 1'b1;
        cell_data  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = cell_ready;
            step();
            n++;
        end
        if (!acc) check("cell_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [19:0] w, input bit gap, input logic [15:0] addr);
        for (int i = 19; i >= 0; i--) send_cell(w[i], gap);
        cell_valid = 1'b0;
        exp_addr.push_back(addr);
        exp_data.push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cell_ready, 1'b0);
        check({tag, "_addr"},  address_a, 16'd0);
        check({tag, "_data"},  data_a, 20'd0);
        check({tag, "_wren"},  wren_a, 1'b0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  frame_done, 1'b0);
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_write_count"}, log_addr.size(), exp_addr.size());
        n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
        end
        log_addr.delete();
        log_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        logic [19:0] w;

        // Reset state
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check("idle_no_ready", cell_ready, 1'b0);

        // Frame 1
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("start_busy",  busy, 1'b1);
        check("start_ready", cell_ready, 1'b1);
        check("start_addr",  address_a, 16'd0);

        // Word 0: alternating cells, valid held high, write visible right after the last acceptance
        send_word(20'hAAAAA, 1'b0, 16'd0);
        check("w0_wren",  wren_a, 1'b1);
        check("w0_addr",  address_a, 16'd0);
        check("w0_data",  data_a, 20'hAAAAA);
        check("w0_ready", cell_ready, 1'b0);
        step();
        check("after_w0_wren",  wren_a, 1'b0);
        check("after_w0_addr",  address_a, 16'd1);
        check("after_w0_hold",  data_a, 20'hAAAAA);
        check("after_w0_ready", cell_ready, 1'b1);

        // Word 1: valid toggling every cycle
        send_word(20'hAAAAA, 1'b1, 16'd1);
        check("w1_addr", address_a, 16'd1);

        // Word 2: stall mid-word with valid low
        w = 20'h12345;
        for (int i = 19; i >= 10; i--) send_cell(w[i], 1'b0);
        cell_valid = 1'b0;
        step();
        step();
        step();
        check("stall_addr", address_a, 16'd2);
        check("stall_wren", wren_a, 1'b0);
        for (int i = 9; i >= 0; i--) send_cell(w[i], 1'b0);
        cell_valid = 1'b0;
        exp_addr.push_back(16'd2);
        exp_data.push_back(w);

        send_word(20'hFFFFF, 1'b0, 16'd3);
        send_word(20'h00001, 1'b0, 16'd4);

        // Word 5: frame_start mid-fill is ignored
        w = 20'hC3C3C;
        for (int i = 19; i >= 12; i--) send_cell(w[i], 1'b0);
        frame_start = 1'b1;
        send_cell(w[11], 1'b0);
        frame_start = 1'b0;
        check("midstart_addr", address_a, 16'd5);
        check("midstart_busy", busy, 1'b1);
        for (int i = 10; i >= 0; i--) send_cell(w[i], 1'b0);
        cell_valid = 1'b0;
        exp_addr.push_back(16'd5);
        exp_data.push_back(w);

        send_word(20'h0F0F0, 1'b0, 16'd6);
        send_word(20'h55555, 1'b0, 16'd7);
        send_word(20'h80000, 1'b0, 16'd8);
        check("last_wren", wren_a, 1'b1);
        check("last_addr", address_a, 16'd8);
        step();
        check("done_pulse", frame_done, 1'b1);
        check("done_addr",  address_a, 16'd0);
        check("done_wren",  wren_a, 1'b0);
        check("done_busy",  busy, 1'b1);
        step();
        check("idle_done", frame_done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", cell_ready, 1'b0);
        check("idle_addr", address_a, 16'd0);
        step();
        check("done_pulse_count", done_pulses, 1);
        compare_log("frame1");

        // Frame 2: reset after 7 cells of word 3
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        send_word(20'h11111, 1'b0, 16'd0);
        send_word(20'h22222, 1'b0, 16'd1);
        send_word(20'h33333, 1'b0, 16'd2);
        for (int i = 0; i < 7; i++) send_cell(1'b1, 1'b0);
        cell_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("postreset_ready", cell_ready, 1'b0);
        check("postreset_busy",  busy, 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        send_word(20'h44444, 1'b0, 16'd0);
        check("restart_addr", address_a, 16'd0);
        check("restart_wren", wren_a, 1'b1);
        step();

`ifdef FB_CELL_WRITER_FLUSH_EN
        // Partial word 1,1,0,1 then flush pads low bits with zeros
        send_cell(1'b1, 1'b0);
        send_cell(1'b1, 1'b0);
        send_cell(1'b0, 1'b0);
        send_cell(1'b1, 1'b0);
        cell_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_wren", wren_a, 1'b1);
        check("flush_data", data_a, 20'hD0000);
        check("flush_addr", address_a, 16'd1);
        exp_addr.push_back(16'd1);
        exp_data.push_back(20'hD0000);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty_wren",  wren_a, 1'b0);
        check("flush_empty_ready", cell_ready, 1'b1);
        step();
`endif

        compare_log("frame2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fb_cell_writer.md
FB_CELL_WRITER -- requirements
Module: fb_cell_writer

Interface
REQ-001 The module SHALL have parameter PIX_PER_WORD, default 20, meaning cells packed per framebuffer word.
REQ-002 The module SHALL have parameter LAST_ADDR, default 16'hFFFF, meaning the final word address of one 1280x1024 frame.
REQ-003 Port clk108  input  1  single clock; all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port frame_start  input  1  one-cycle pulse from display side; the framebuffer may be rewritten.
REQ-006 Port cell_valid  input  1  producer presents a cell.
REQ-007 Port cell_data  input  1  cell state (1 = live/white).
REQ-008 Port cell_ready  output  1  writer accepts a cell this cycle.
REQ-009 Port address_a  output  16  framebuffer write-port address.
REQ-010 Port data_a  output  20  framebuffer write-port data.
REQ-011 Port wren_a  output  1  framebuffer write enable.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port frame_done  output  1  one-cycle pulse after the last word of a frame is written.

Function
REQ-014 A cell SHALL be accepted only on a cycle with cell_valid=1 and cell_ready=1.
REQ-015 States SHALL be IDLE, FILL, WRITE and DONE.
REQ-016 In IDLE, cell_ready SHALL be 0; a frame_start pulse SHALL move the block to FILL on the next edge with address_a=0 and bit count=0.
REQ-017 In FILL, cell_ready SHALL be 1; each accepted cell SHALL fill word bits MSB first (first cell -> bit 19, 20th cell -> bit 0), matching the display's left-to-right draw order.
REQ-018 On acceptance of the PIX_PER_WORD-th cell, the block SHALL enter WRITE on the next edge.
REQ-019 In WRITE (exactly one cycle), wren_a SHALL be 1, data_a SHALL hold the packed word, address_a SHALL hold the current word address, and cell_ready SHALL be 0.
REQ-020 Leaving WRITE, address_a SHALL increment by 1 and the bit count SHALL clear; if address_a was LAST_ADDR the block SHALL enter DONE and address_a SHALL wrap to 0, otherwise it SHALL return to FILL.
REQ-021 In DONE (one cycle), frame_done SHALL be 1; the block SHALL then enter IDLE.
REQ-022 Latency SHALL be exactly one cycle from the edge accepting the last cell of a word to wren_a=1; throughput SHALL be 20 cells per 21 cycles under continuous cell_valid.
REQ-023 frame_start SHALL be ignored outside IDLE; no frame SHALL be restarted mid-write.
REQ-024 cell_valid=0 in FILL SHALL stall without losing packed bits or changing address_a.
REQ-025 wren_a SHALL be 0 in every state except WRITE; data_a SHALL be held stable outside WRITE.

Reset
REQ-026 Reset SHALL force state=IDLE, address_a=0, data_a=0, wren_a=0, cell_ready=0, busy=0, frame_done=0, and clear the bit count.
REQ-027 Reset asserted mid-frame SHALL discard the partial word with no further write; a new frame_start SHALL be required afterwards.

Configuration
REQ-028 With macro FB_CELL_WRITER_FLUSH_EN defined, an input port flush (1 bit) SHALL exist; flush=1 in FILL with bit count>0 SHALL zero-pad the remaining low bits and enter WRITE, the cell accepted on the same cycle being included before padding; flush with bit count=0 SHALL have no effect.
REQ-029 Without FB_CELL_WRITER_FLUSH_EN, the flush port and its logic SHALL be absent, and words SHALL be written only when full.

Verification
REQ-030 Reset, frame_start, 20 cells alternating 1,0,... with cell_valid held high -> one cycle later wren_a=1, address_a=0, data_a=20'hAAAAA; next word written at address 1.
REQ-031 Full frame of 1,310,720 cells all 1 -> 65536 writes of 20'hFFFFF, addresses 0..65535, single frame_done pulse, then IDLE with address_a=0.
REQ-032 cell_valid toggled 0/1 every cycle -> identical data_a/address_a sequence to REQ-030, with write timing stretched.
REQ-033 frame_start pulsed during FILL at address 5 -> no restart; address_a continues 5,6,...
REQ-034 Reset after 7 cells of word 3 -> all outputs at reset values, no write to address 3; after frame_start, the first write goes to address 0.
REQ-035 With FB_CELL_WRITER_FLUSH_EN: 4 cells 1,1,0,1 then flush -> wren_a=1, data_a=20'hD0000; without the macro, the flush port is absent and the module elaborates.
